// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: read ports, write ports, scoreboard claim/flush and busy count.
// Parameters must match the regfile instance it is attached to.
interface regfile_mp_sb_if #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [NRD*AW-1:0] rsel;
  logic [NRD*DW-1:0] rdat;
  logic [NRD-1:0]    rbusy;
  logic [NWR-1:0]    WEN;
  logic [NWR*AW-1:0] wsel;
  logic [NWR*DW-1:0] wdat;
  logic              claim_en;
  logic [AW-1:0]     claim_sel;
  logic              flush;
  logic [CW-1:0]     busy_cnt;

  modport master (
    output rsel, WEN, wsel, wdat, claim_en, claim_sel, flush,
    input  rdat, rbusy, busy_cnt
  );

  modport slave (
    input  rsel, WEN, wsel, wdat, claim_en, claim_sel, flush,
    output rdat, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard; register 0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp_sb #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
) (
  input  logic           CLK,
  input  logic           RST,
  regfile_mp_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [DW-1:0]     r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [CW-1:0]     r_busyCnt;
  logic [NREG-1:0]   w_busyNext;
  logic [CW-1:0]     w_cntNext;
  logic [NRD*DW-1:0] w_rdat;
  logic [NRD-1:0]    w_rbusy;

  // Later ports are assigned last, so the highest-indexed port wins a same-register conflict.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.WEN[j] && (bus.wsel[j*AW +: AW] != '0))
          r_regs[bus.wsel[j*AW +: AW]] <= bus.wdat[j*DW +: DW];
      end
    end
  end

  // Priority lowest to highest: retiring write, younger claim, flush.
  always_comb begin
    w_busyNext = r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (bus.WEN[j]) w_busyNext[bus.wsel[j*AW +: AW]] = 1'b0;
    end
    if (bus.claim_en && (bus.claim_sel != '0)) w_busyNext[bus.claim_sel] = 1'b1;
    if (bus.flush) w_busyNext = '0;
    w_busyNext[0] = 1'b0;
  end

  always_comb begin
    w_cntNext = '0;
    for (int r = 0; r < NREG; r++) w_cntNext = w_cntNext + {{(CW-1){1'b0}}, w_busyNext[r]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      r_busy    <= w_busyNext;
      r_busyCnt <= w_cntNext;
    end
  end

  always_comb begin
    w_rdat  = '0;
    w_rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rdat[i*DW +: DW] = r_regs[bus.rsel[i*AW +: AW]];
      w_rbusy[i]         = r_busy[bus.rsel[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (bus.WEN[j] && (bus.wsel[j*AW +: AW] == bus.rsel[i*AW +: AW]) &&
            (bus.rsel[i*AW +: AW] != '0)) begin
          w_rdat[i*DW +: DW] = bus.wdat[j*DW +: DW];
          w_rbusy[i]         = 1'b0;
        end
      end
      if (RST) begin
        w_rdat[i*DW +: DW] = '0;
        w_rbusy[i]         = 1'b0;
      end
`endif
    end
  end

  assign bus.rdat     = w_rdat;
  assign bus.rbusy    = w_rbusy;
  assign bus.busy_cnt = r_busyCnt;
endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port register file with an integrated per-register busy scoreboard, the next-generation register file for the pipelined MIPS datapath. It provides NRD combinational read ports and NWR clocked write ports, hardwires register 0 to zero, and tracks which registers have an outstanding in-flight write so decode can detect RAW hazards. Sits between decode (reads, claims) and writeback (writes).

## Interface
- DW, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports
- NWR, 1, number of write ports
- AW, $clog2(NREG), register index width (derived, not overridden)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- rsel  in  NRD*AW  read selects; port i uses bits [i*AW +: AW]
- rdat  out  NRD*DW  read data; port i uses bits [i*DW +: DW]
- rbusy  out  NRD  scoreboard busy bit of the register selected on each read port
- WEN  in  NWR  per-port write enable
- wsel  in  NWR*AW  write selects, packed like rsel
- wdat  in  NWR*DW  write data, packed like rdat
- claim_en  in  1  mark register claim_sel busy (instruction issued with that destination)
- claim_sel  in  AW  destination being claimed
- flush  in  1  clear every busy bit (pipeline squash)
- busy_cnt  out  $clog2(NREG+1)  number of registers currently busy

## Operation
- State: reg array NREG×DW, busy vector NREG bits, busy_cnt register.
- Write: on rising CLK, for each port j with WEN[j]=1 and wsel[j]≠0, reg[wsel[j]] ← wdat[j]. Two ports targeting the same register in one cycle: highest-indexed port wins.
- Register 0: writes ignored, always reads 0, claims ignored, busy[0] constantly 0.
- Read: rdat[i] = reg[rsel[i]], rbusy[i] = busy[rsel[i]]; purely combinational from stored state (see Configuration for bypass).
- Scoreboard next-state per register r, priority highest first:
  - flush=1 → busy[r] ← 0 (same-cycle claim discarded; writes still performed).
  - claim_en=1 and claim_sel=r (r≠0) → busy[r] ← 1, even if a write to r occurs the same cycle (new claim is younger than retiring write).
  - any WEN[j]=1 with wsel[j]=r → busy[r] ← 0.
  - otherwise hold.
- busy_cnt always equals the popcount of the busy vector after the same edge; it is registered, not combinational.
- No overflow/underflow possible: claiming an already-busy register keeps it busy, count unchanged; writing a non-busy register leaves count unchanged.

## Timing
- Reset: while RST=1, reg array, busy vector and busy_cnt are 0 immediately (asynchronous); rdat=0 and rbusy=0 on every port regardless of rsel. Deassertion mid-operation: first update occurs on the first rising CLK with RST=0.
- Write latency: data written at edge k is visible on rdat after edge k (same cycle only with bypass).
- Claim latency: rbusy rises after the claiming edge; busy_cnt increments at that same edge.
- Writeback clear: rbusy falls after the writing edge.
- No handshakes; every input is sampled every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: read ports forward same-cycle write data. If any WEN[j]=1 with wsel[j]=rsel[i]≠0, rdat[i]=wdat of the highest such j and rbusy[i]=0 (unless RST=1). Combinational path from wdat/wsel/WEN to rdat/rbusy.
- Not defined: reads return stored state only; no combinational path from write ports to read ports.

## Test plan
- Reset: pulse RST between edges with reg 5 holding 0xDEADBEEF, busy[5]=1 → rdat reads 0 and busy_cnt=0 immediately, before any edge.
- Write/read: WEN[0]=1, wsel=3, wdat=0x1234 at edge 1; rsel[1]=3 → rdat[1]=0x1234 after edge 1; rsel=0 after a write of 0xFFFFFFFF to reg 0 → rdat=0.
- Scoreboard: claim 7, claim 9 → busy_cnt=2, rbusy for 7 =1; write reg 7 → busy_cnt=1; claim 7 and write 7 same cycle → busy stays 1, busy_cnt=2.
- Flush: regs 2,4,6 busy, flush=1 with claim_sel=8 → busy_cnt=0, rbusy for 8 =0; write issued that cycle still lands.
- Multi-write conflict (NWR=2): both ports write reg 10 with 0xA and 0xB → reg 10 reads 0xB.
- Bypass (REGFILE_BYPASS_EN): reg 12 busy, holding 0x1; write 0x55 to 12 while rsel=12 → same-cycle rdat=0x55, rbusy=0; without macro rdat=0x1, rbusy=1 until the edge.
